// File: rtl/conv_kxk_stream.sv
// Streaming KxK valid-mode convolution: line buffers feed a KxK window, then a
// 3-stage MAC pipeline (products, adder tree + bias, shift/saturate/relu).
module conv_kxk_stream #(
  parameter int DW    = 10,
  parameter int K     = 3,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int SHIFT = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [DW-1:0]      in_data,
  input  logic [K*K*DW-1:0]  w,
  input  logic [DW-1:0]      b,
  input  logic               relu,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NT = K * K;
  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + $clog2(NT) + 1;

  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_eff;

  logic signed [DW-1:0] lb    [K-1][IMG_W];
  logic signed [DW-1:0] lb_rd [K-1];
  logic signed [DW-1:0] win   [K][K];
  logic                 win_vld, win_last;

  logic signed [DW-1:0] w_r [NT];
  logic signed [DW-1:0] b_r;
  logic                 relu_r;

  logic signed [PW-1:0] prod [NT];
  logic signed [AW-1:0] bias_p1, sum_p2, tree_sum, sh;
  logic                 v1, l1, r1, v2, l2, r2;
  logic [DW-1:0]        res;

  // An accepted sof pixel is column 0 / row 0 regardless of the counters.
  assign col_eff = in_sof ? '0 : col;
  assign row_eff = in_sof ? '0 : row;

  always_comb begin
    for (int n = 0; n < K - 1; n++) begin
      lb_rd[n] = lb[n][col_eff];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb[0][col_eff] <= in_data;
      for (int n = 1; n < K - 1; n++) begin
        lb[n][col_eff] <= lb_rd[n-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col      <= '0;
      row      <= '0;
      win_vld  <= 1'b0;
      win_last <= 1'b0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      win_vld  <= 1'b0;
      win_last <= 1'b0;
      if (in_valid) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++) begin
            win[i][j] <= win[i][j+1];
          end
        end
        // Oldest row comes from the deepest line buffer.
        for (int i = 0; i < K - 1; i++) begin
          win[i][K-1] <= lb_rd[K-2-i];
        end
        win[K-1][K-1] <= in_data;
        win_vld  <= (row_eff >= ROW_FIRST) && (col_eff >= COL_FIRST);
        win_last <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
        end else begin
          col <= col_eff + 1'b1;
          row <= row_eff;
        end
      end
    end
  end

  // Config is held while in reset so the value present at reset exit sticks.
  always_ff @(posedge clk) begin
    if (!resetn || (in_valid && in_sof)) begin
      for (int k = 0; k < NT; k++) begin
        w_r[k] <= w[k*DW +: DW];
      end
      b_r    <= b;
      relu_r <= relu;
    end
  end

  always_comb begin
    tree_sum = bias_p1;
    for (int k = 0; k < NT; k++) begin
      tree_sum = tree_sum + {{(AW-PW){prod[k][PW-1]}}, prod[k]};
    end
  end

  always_comb begin
    sh = sum_p2 >>> SHIFT;
    if (sh > SAT_MAX) begin
      res = OUT_MAX;
    end else if (sh < SAT_MIN) begin
      res = OUT_MIN;
    end else begin
      res = sh[DW-1:0];
    end
    if (r2 && res[DW-1]) begin
      res = '0;
    end
  end

  // Bias and relu travel with their window so a new frame's config cannot
  // leak into results still in flight.
  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod[i*K+j] <= PW'(win[i][j]) * PW'(w_r[i*K+j]);
      end
    end
    bias_p1 <= ({{(AW-DW){b_r[DW-1]}}, b_r}) <<< SHIFT;
    r1      <= relu_r;
    sum_p2  <= tree_sum;
    r2      <= r1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1        <= 1'b0;
      l1        <= 1'b0;
      v2        <= 1'b0;
      l2        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      v1        <= win_vld;
      l1        <= win_last;
      v2        <= v1;
      l2        <= l1;
      out_valid <= v2;
      out_last  <= l2;
      out_data  <= res;
    end
  end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Scoreboard bench for conv_kxk_stream: a frame-image reference model predicts
// each window result and its output edge; a negedge monitor pops and compares.
module tb_conv_kxk_stream;
  localparam int DW = 10;
  localparam int K = 3;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int SHIFT = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic relu = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] b = '0;
  logic [K*K*DW-1:0] w = '0;
  logic out_valid, out_last;
  logic [DW-1:0] out_data;

  conv_kxk_stream #(.DW(DW), .K(K), .IMG_W(IW), .IMG_H(IH), .SHIFT(SHIFT)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .w(w), .b(b), .relu(relu),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int n_pass = 0, n_total = 0;
  int out_cnt = 0, last_cnt = 0;

  typedef struct {int data; bit last; int at;} exp_t;
  exp_t sb[$];

  int img[IH][IW];
  int wm[K][K];
  int bm;
  bit rm;
  int mcol = 0, mrow = 0;

  function void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      out_cnt++;
      if (out_last) last_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_data", $signed(out_data), e.data);
        check("out_last", int'(out_last), int'(e.last));
        check("out_latency", ecnt, e.at);
      end
    end
  end

  function void capture();
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        wm[i][j] = $signed(w[(i*K+j)*DW +: DW]);
    bm = $signed(b);
    rm = relu;
  endfunction

  // Result for the window whose newest pixel is (r,c): floor division, clamp, relu.
  function int ref_val(int r, int c);
    int acc, q, scale;
    scale = 1 << SHIFT;
    acc = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc += img[r-K+1+i][c-K+1+j] * wm[i][j];
    acc += bm * scale;
    q = acc / scale;
    if ((acc % scale) != 0 && acc < 0) q--;
    if (q > (1 << (DW-1)) - 1) q = (1 << (DW-1)) - 1;
    if (q < -(1 << (DW-1))) q = -(1 << (DW-1));
    if (rm && q < 0) q = 0;
    return q;
  endfunction

  function void model_accept(bit sof, int data, int edge_no);
    exp_t e;
    if (sof) begin
      mcol = 0;
      mrow = 0;
      capture();
    end
    img[mrow][mcol] = data;
    if (mrow >= K-1 && mcol >= K-1) begin
      e.data = ref_val(mrow, mcol);
      e.last = (mrow == IH-1) && (mcol == IW-1);
      e.at = edge_no + 3;
      sb.push_back(e);
    end
    mcol++;
    if (mcol == IW) begin
      mcol = 0;
      mrow = (mrow == IH-1) ? 0 : mrow + 1;
    end
  endfunction

  function void model_reset();
    sb.delete();
    mcol = 0;
    mrow = 0;
    capture();
  endfunction

  task automatic px(input bit sof, input int data);
    in_valid = 1'b1;
    in_sof = sof;
    in_data = DW'(data);
    model_accept(sof, data, ecnt + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_sof = 1'($urandom_range(0, 1));
      in_data = DW'($urandom);
      @(posedge clk); #1;
    end
    in_sof = 1'b0;
  endtask

  // pmode 0: constant pval; 1: random pixels plus a mid-frame weight change.
  // gapmode 0: back-to-back; 1: alternate idle; 2: random idles.
  task automatic frame(input bit sof_first, input int npix, input int pmode,
                       input int pval, input int gapmode);
    int d;
    for (int p = 0; p < npix; p++) begin
      d = (pmode == 1) ? int'($urandom_range(0, 1023)) - 512 : pval;
      if (pmode == 1 && p == 20) begin
        for (int k = 0; k < K*K; k++) w[k*DW +: DW] = DW'($urandom);
        b = DW'($urandom);
        relu = ~relu;
      end
      px(sof_first && p == 0, d);
      if (gapmode == 1) idle(1);
      else if (gapmode == 2) idle($urandom_range(0, 2));
    end
  endtask

  task automatic drain();
    idle(8);
    check("drained", sb.size(), 0);
  endtask

  task automatic set_w_all(input int v);
    for (int k = 0; k < K*K; k++) w[k*DW +: DW] = DW'(v);
  endtask

  task automatic set_w_center(input int v);
    w = '0;
    w[(1*K+1)*DW +: DW] = DW'(v);
  endtask

  int c0, l0;

  initial begin
    set_w_all(16);
    b = '0;
    relu = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_data", $signed(out_data), 0);
    resetn = 1'b1;
    model_reset();

    // unit weights (16 >> SHIFT) on all-ones: 9 per window, continuous and gapped
    c0 = out_cnt; l0 = last_cnt;
    frame(1, 64, 0, 1, 0);
    drain();
    check("frame_outputs", out_cnt - c0, 36);
    check("frame_lasts", last_cnt - l0, 1);

    c0 = out_cnt; l0 = last_cnt;
    frame(1, 64, 0, 1, 1);
    drain();
    check("gapped_outputs", out_cnt - c0, 36);
    check("gapped_lasts", last_cnt - l0, 1);

    // saturation at both ends and relu clamp
    set_w_center(127);
    frame(1, 64, 0, 511, 0);
    relu = 1'b1;
    frame(1, 64, 0, -511, 0);
    relu = 1'b0;
    frame(1, 64, 0, -511, 0);
    drain();

    // bias with fractional shift
    set_w_all(16);
    b = DW'(-2);
    frame(1, 64, 0, 3, 0);
    drain();

    // random config and pixels; third frame wraps without sof
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < K*K; k++) w[k*DW +: DW] = DW'($urandom);
      b = DW'($urandom);
      relu = 1'($urandom_range(0, 1));
      frame(t != 2, 64, 1, 0, 2);
    end
    drain();

    // mid-frame sof after 30 pixels, then a full frame
    set_w_all(16);
    b = '0;
    relu = 1'b0;
    c0 = out_cnt; l0 = last_cnt;
    frame(1, 30, 1, 0, 0);
    frame(1, 64, 1, 0, 0);
    drain();
    check("midsof_outputs", out_cnt - c0, 46);
    check("midsof_lasts", last_cnt - l0, 1);

    // one-cycle reset with three results in flight
    frame(1, 30, 1, 0, 0);
    resetn = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    c0 = out_cnt; l0 = last_cnt;
    frame(0, 2*IW + 2, 1, 0, 0);
    check("post_reset_quiet", out_cnt - c0, 0);
    frame(0, IW*IH - (2*IW + 2), 1, 0, 0);
    drain();
    check("post_reset_outputs", out_cnt - c0, 36);
    check("post_reset_lasts", last_cnt - l0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
